// File: rtl/pipelined_datapath.sv
// Three-stage valid/ready datapath: S1 captures operands, S2 forms the two
// (optionally saturating) sums and their XOR, S3 selects and drives the results.
// A completed-transfer counter tracks every out_valid && out_ready handshake.
module pipelined_datapath #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [WIDTH-1:0]   in_c,
  input  logic               sat_mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_x,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] out_count
);

  // Add with optional clamp to all-ones when the carry-out is set.
  function automatic logic [WIDTH-1:0] add_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic             sat);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (sat && s[WIDTH]) ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  // S1: operand capture
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
  logic             s1_sat_q, s1_sat_d;
  // S2: sums and combine
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] s2_sum1_q, s2_sum1_d, s2_sum2_q, s2_sum2_d, s2_comb_q, s2_comb_d;
  // S3: output registers
  logic             s3_valid_q, s3_valid_d;
  logic [WIDTH-1:0] s3_x_q, s3_x_d, s3_y_q, s3_y_d;
  logic [COUNT_W-1:0] count_q, count_d;

  logic             en3, en2, en1;
  logic [WIDTH-1:0] sum1_c, sum2_c;

  // Stage enables: a stage may load when its content is leaving or it is empty.
  always_comb begin
    en3 = out_ready || !s3_valid_q;
    en2 = en3 || !s2_valid_q;
    en1 = en2 || !s1_valid_q;
  end

  assign in_ready  = en1;
  assign out_x     = s3_x_q;
  assign out_y     = s3_y_q;
  assign out_valid = s3_valid_q;
  assign out_count = count_q;

  // Next-state for all three stages and the transfer counter.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_sat_d   = s1_sat_q;
    s2_valid_d = s2_valid_q;
    s2_sum1_d  = s2_sum1_q;
    s2_sum2_d  = s2_sum2_q;
    s2_comb_d  = s2_comb_q;
    s3_valid_d = s3_valid_q;
    s3_x_d     = s3_x_q;
    s3_y_d     = s3_y_q;
    count_d    = count_q;
    sum1_c     = add_op(s1_a_q, s1_b_q, s1_sat_q);
    sum2_c     = add_op(s1_b_q, s1_c_q, s1_sat_q);

    if (en1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d   = in_a;
        s1_b_d   = in_b;
        s1_c_d   = in_c;
        s1_sat_d = sat_mode;
      end
    end

    if (en2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sum1_d = sum1_c;
        s2_sum2_d = sum2_c;
        s2_comb_d = sum1_c ^ sum2_c;
      end
    end

    if (en3) begin
      s3_valid_d = s2_valid_q;
      if (s2_valid_q) begin
        s3_x_d = s2_comb_q[0] ? s2_sum1_q : s2_comb_q;
        s3_y_d = s2_sum1_q[1] ? s2_sum2_q : s2_sum1_q;
      end
    end

    if (s3_valid_q && out_ready) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // State registers; reset discards anything in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_c_q     <= '0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_sum1_q  <= '0;
      s2_sum2_q  <= '0;
      s2_comb_q  <= '0;
      s3_valid_q <= 1'b0;
      s3_x_q     <= '0;
      s3_y_q     <= '0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_c_q     <= s1_c_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      s2_sum1_q  <= s2_sum1_d;
      s2_sum2_q  <= s2_sum2_d;
      s2_comb_q  <= s2_comb_d;
      s3_valid_q <= s3_valid_d;
      s3_x_q     <= s3_x_d;
      s3_y_q     <= s3_y_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench: randomized and directed traffic against a queue-based
// reference model; a second instance with a 4-bit counter checks wrap-around.
module tb_pipelined_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_a, in_b, in_c;
  logic       sat_mode, in_valid, out_ready;
  logic       in_ready, out_valid;
  logic [7:0] out_x, out_y;
  logic [15:0] out_count;
  logic       in_ready4, out_valid4;
  logic [7:0] out_x4, out_y4;
  logic [3:0] out_count4;

  pipelined_datapath #(.WIDTH(8), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .sat_mode(sat_mode), .in_valid(in_valid), .in_ready(in_ready),
    .out_x(out_x), .out_y(out_y), .out_valid(out_valid), .out_ready(out_ready),
    .out_count(out_count)
  );

  pipelined_datapath #(.WIDTH(8), .COUNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .sat_mode(sat_mode), .in_valid(in_valid), .in_ready(in_ready4),
    .out_x(out_x4), .out_y(out_y4), .out_valid(out_valid4), .out_ready(out_ready),
    .out_count(out_count4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int t;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   count_m = 0;
  int   t = 0;
  int   first_pop = -1;
  int   last_pop = -1;
  bit   lat_exact = 1'b0;
  bit   prev_stall = 1'b0;
  logic [7:0] px, py;
  logic       pv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: sums with wrap or clamp, XOR, then the two selects.
  function automatic void model(input int a, input int b, input int c, input bit sat,
                                output int x, output int y);
    int s1, s2, cm;
    s1 = a + b;
    s2 = b + c;
    if (sat) begin
      if (s1 > 255) s1 = 255;
      if (s2 > 255) s2 = 255;
    end else begin
      s1 = s1 % 256;
      s2 = s2 % 256;
    end
    cm = s1 ^ s2;
    x  = (cm % 2 == 1) ? s1 : cm;
    y  = ((s1 / 2) % 2 == 1) ? s2 : s1;
  endfunction

  // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic cycle(input bit v, input bit r, input bit sat, input int a, input int b,
                       input int c, output bit acc);
    exp_t e;
    int   x, y;
    in_valid  = v;
    out_ready = r;
    sat_mode  = sat;
    in_a      = a[7:0];
    in_b      = b[7:0];
    in_c      = c[7:0];
    @(negedge clk);
    if (prev_stall) begin
      check("hold_x", out_x, px);
      check("hold_y", out_y, py);
      check("hold_valid", out_valid, pv);
    end
    check("in_ready", in_ready, (q.size() < 3) || r);
    check("count", out_count, count_m % 65536);
    check("count4", out_count4, count_m % 16);
    if (q.size() == 0) check("idle_valid", out_valid, 0);
    if (out_valid && r && q.size() > 0) begin
      e = q.pop_front();
      check("out_x", out_x, e.x);
      check("out_y", out_y, e.y);
      check("latency_min", (t - e.t) >= 3, 1);
      if (lat_exact) check("latency", t - e.t, 3);
      count_m++;
      if (first_pop < 0) first_pop = t;
      last_pop = t;
    end
    prev_stall = out_valid && !r;
    px = out_x;
    py = out_y;
    pv = out_valid;
    acc = v && in_ready;
    if (acc) begin
      model(a, b, c, sat, x, y);
      e.x = x;
      e.y = y;
      e.t = t;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    t++;
  endtask

  // Asynchronous reset pulse between edges; effect is checked before any edge.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_x", out_x, 0);
    check("rst_y", out_y, 0);
    reset = 1'b0;
    q.delete();
    count_m    = 0;
    prev_stall = 1'b0;
    first_pop  = -1;
    last_pop   = -1;
  endtask

  initial begin
    bit acc;
    int sent;
    int k;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sat_mode  = 1'b0;
    in_a = '0;
    in_b = '0;
    in_c = '0;
    #1;
    check("init_valid", out_valid, 0);
    check("init_x", out_x, 0);
    check("init_y", out_y, 0);
    check("init_count", out_count, 0);
    #2 reset = 1'b0;
    @(posedge clk);
    #1;
    check("init_in_ready", in_ready, 1);

    // Wrapping vector with exact latency.
    cycle(1, 1, 0, 'h10, 'h20, 'h30, acc);
    cycle(0, 1, 0, 0, 0, 0, acc);
    check("lat_early", out_valid, 0);
    cycle(0, 1, 0, 0, 0, 0, acc);
    check("wrap_valid", out_valid, 1);
    check("wrap_x", out_x, 'h60);
    check("wrap_y", out_y, 'h30);
    cycle(0, 1, 0, 0, 0, 0, acc);

    // Overflow vector, wrap then saturate back-to-back.
    cycle(1, 1, 0, 'hF0, 'h20, 'h01, acc);
    cycle(1, 1, 1, 'hF0, 'h20, 'h01, acc);
    cycle(0, 1, 0, 0, 0, 0, acc);
    check("ovf_wrap_x", out_x, 'h10);
    check("ovf_wrap_y", out_y, 'h10);
    cycle(0, 1, 0, 0, 0, 0, acc);
    check("ovf_sat_x", out_x, 'hDE);
    check("ovf_sat_y", out_y, 'h21);
    for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0, 0, acc);

    // Backpressure: 6 transactions, out_ready low for 5 cycles mid-stream.
    do_reset();
    sent = 0;
    k = 0;
    while (sent < 6 && k < 50) begin
      cycle(1, !(k >= 3 && k < 8), $urandom_range(0, 1), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255), acc);
      if (acc) sent++;
      k++;
    end
    check("bp_sent", sent, 6);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0, 0, 0, acc);
    check("bp_count", out_count, 6);

    // Throughput: 100 back-to-back with exact latency.
    do_reset();
    lat_exact = 1'b1;
    for (int i = 0; i < 100; i++) begin
      cycle(1, 1, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), acc);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, acc);
    lat_exact = 1'b0;
    check("tp_count", out_count, 100);
    check("tp_span", last_pop - first_pop, 99);

    // Reset with 3 in flight; nothing stale may emerge afterwards.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 'h55, 'h66, 'h77, acc);
    do_reset();
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0, 0, 0, acc);

    // Counter wrap on the 4-bit instance.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1, 1, 0, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), acc);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 0, acc);
    check("wrap4_count", out_count4, 1);
    check("count17", out_count, 17);

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1), $urandom_range(0, 9) < 7, $urandom_range(0, 1),
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), acc);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) cycle(0, 1, 0, 0, 0, 0, acc);
    check("drain_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_datapath.md
PIPELINED_DATAPATH -- requirements
Module: pipelined_datapath

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every operand and result.
REQ-002 SHALL have parameter COUNT_W, default 16, width of transfer counter.
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_a, in_b, in_c  input  WIDTH each  operands.
REQ-006 SHALL have port sat_mode  input  1  0 = wrapping add, 1 = saturating add; sampled with operands.
REQ-007 SHALL have port in_valid  input  1  operands valid.
REQ-008 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-009 SHALL have port out_x, out_y  output  WIDTH each  results.
REQ-010 SHALL have port out_valid  output  1  results valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts results.
REQ-012 SHALL have port out_count  output  COUNT_W  number of completed output transfers.

Function
REQ-013 SHALL implement three register stages: S1 operand capture, S2 add/combine, S3 mux/output; each stage holds a valid bit.
REQ-014 SHALL accept a transaction on a rising edge where in_valid && in_ready; S1 captures in_a, in_b, in_c, sat_mode.
REQ-015 SHALL compute in S2: sum1 = a + b, sum2 = b + c; wrapping mod 2^WIDTH if sat_mode = 0, clamped to 2^WIDTH-1 on carry-out if sat_mode = 1.
REQ-016 SHALL compute in S2: comb = sum1 XOR sum2; S2 registers sum1, sum2, comb.
REQ-017 SHALL compute into S3: out_x = comb[0] ? sum1 : comb; out_y = sum1[1] ? sum2 : sum1.
REQ-018 SHALL drive out_x, out_y, out_valid directly from S3 registers (no combinational path from inputs to outputs).
REQ-019 SHALL give latency of 3 edges: transaction accepted at edge N appears with out_valid = 1 after edge N+2 when out_ready is held 1.
REQ-020 SHALL advance stage k when its successor is empty or advancing in the same cycle; S3 advances when out_ready = 1 or out_valid = 0.
REQ-021 SHALL drive in_ready = !S1.valid || S1 advancing; in_ready SHALL depend combinationally on out_ready only through this chain.
REQ-022 SHALL hold out_x, out_y, out_valid stable while out_valid = 1 and out_ready = 0.
REQ-023 SHALL sustain one transfer per cycle when in_valid and out_ready are continuously 1.
REQ-024 SHALL never drop, duplicate or reorder transactions under any in_valid/out_ready pattern.
REQ-025 SHALL apply sat_mode per transaction; a sat_mode change between back-to-back transactions SHALL affect only the later one.
REQ-026 SHALL increment out_count by 1 on each edge with out_valid && out_ready, wrapping from 2^COUNT_W-1 to 0.
REQ-027 SHALL, when all three stages are full and out_ready = 0, drive in_ready = 0; simultaneous out_ready = 1 and in_valid = 1 on that cycle SHALL accept the new transaction.

Reset
REQ-028 SHALL, on reset = 1, immediately clear all stage valid bits, out_valid = 0, out_x = 0, out_y = 0, out_count = 0, independent of clk.
REQ-029 SHALL drive in_ready = 1 while reset is deasserted and pipeline empty; in-flight transactions at reset assertion SHALL be discarded.
REQ-030 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification (WIDTH = 8)
REQ-031 SHALL verify wrap: a=0x10, b=0x20, c=0x30, sat_mode=0 -> out_x=0x60, out_y=0x30, out_valid after 3 edges.
REQ-032 SHALL verify overflow: a=0xF0, b=0x20, c=0x01, sat_mode=0 -> out_x=0x10, out_y=0x10; same with sat_mode=1 -> out_x=0xDE, out_y=0x21.
REQ-033 SHALL verify backpressure: stream 6 transactions, out_ready=0 for 5 cycles mid-stream -> in_ready falls after 3 held, outputs stable, all 6 results in order, out_count=6.
REQ-034 SHALL verify throughput: 100 back-to-back transactions with out_ready=1 -> 100 outputs on 100 consecutive cycles, out_count=100.
REQ-035 SHALL verify reset mid-operation: assert reset asynchronously with 3 in flight -> out_valid=0, out_count=0 before next edge; no stale result after release.
REQ-036 SHALL verify counter wrap with COUNT_W=4: 17 transfers -> out_count=1.
